// File: rtl/vx_stream_arbiter.sv
// Round-robin N-to-1 valid/ready arbiter feeding a registered 2-entry output FIFO.
// Each output beat carries the index of the stream it came from.
module vx_stream_arbiter #(
    parameter  int unsigned NUM_REQS = 4,
    parameter  int unsigned DATAW    = 32,
    localparam int unsigned SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
);

    typedef struct packed {
        logic [SELW-1:0]  sel;
        logic [DATAW-1:0] data;
    } entry_t;

    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]          count_q, count_d;
    entry_t              head_q, head_d;
    entry_t              tail_q, tail_d;
    entry_t              new_entry;

    logic [DATAW-1:0]    data_arr [NUM_REQS];
    logic [SELW-1:0]     grant_idx;
    logic [SELW-1:0]     cand_idx;
    logic                grant_found;
    logic [NUM_REQS-1:0] grant_vec;
    logic                full;
    logic                push;
    logic                pop;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign data_arr[g] = data_in[g*DATAW +: DATAW];
    end

    // Cyclic first-valid search starting at the priority pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand_idx = SELW'((32'(rr_ptr_q) + k) % NUM_REQS);
            if (!grant_found && valid_in[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_vec            = '0;
        grant_vec[grant_idx] = grant_found;
        full                 = (count_q == 2'd2);
        ready_in             = reset ? '0 : (grant_vec & ~{NUM_REQS{full}});
        push                 = grant_found & ~full & ~reset;
        valid_out            = (count_q != 2'd0);
        pop                  = valid_out & ready_out;
        data_out             = head_q.data;
        sel_out              = head_q.sel;
    end

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        rr_ptr_d       = rr_ptr_q;
        new_entry.sel  = grant_idx;
        new_entry.data = data_arr[grant_idx];
        if (push) begin
            rr_ptr_d = SELW'((32'(grant_idx) + 1) % NUM_REQS);
        end
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // push excludes full and pop excludes empty, so count is 1 here
            2'b11: head_d = new_entry;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule

// File: tb/tb_vx_stream_arbiter.sv
// Directed bench for vx_stream_arbiter (NUM_REQS=4, DATAW=32): per-cycle vector
// table plus hand-written reset-mid-operation and push/pop sequences.
module tb_vx_stream_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   valid_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ready_in;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [1:0]     sel_out;
    logic           ready_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    vx_stream_arbiter #(.NUM_REQS(N), .DATAW(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    typedef struct {
        logic [3:0]   vin;
        logic [127:0] din;
        logic         ro;
        logic [3:0]   rin;
        logic         vout;
        logic [31:0]  dout;
        logic [1:0]   sel;
    } vec_t;

    vec_t vecs [20];

    localparam logic [127:0] DZ   = '0;
    localparam logic [127:0] DA5  = {32'h0, 32'hA5, 32'h0, 32'h0};
    localparam logic [127:0] DWR  = {32'h0, 32'h0, 32'h101, 32'h100};
    localparam logic [127:0] DALL = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    localparam logic [127:0] DBP  = {32'h33, 32'h0, 32'h11, 32'h0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic rst, input logic [3:0] vin, input logic [127:0] din, input logic ro);
        reset     = rst;
        valid_in  = vin;
        data_in   = din;
        ready_out = ro;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b0100, DA5,  1'b1, 4'b0100, 1'b0, 32'h0,   2'd0};
        vecs[1]  = '{4'b0000, DZ,   1'b1, 4'b0000, 1'b1, 32'hA5,  2'd2};
        vecs[2]  = '{4'b0011, DWR,  1'b1, 4'b0001, 1'b0, 32'h0,   2'd0};
        vecs[3]  = '{4'b0011, DWR,  1'b1, 4'b0010, 1'b1, 32'h100, 2'd0};
        vecs[4]  = '{4'b0011, DWR,  1'b1, 4'b0001, 1'b1, 32'h101, 2'd1};
        vecs[5]  = '{4'b0000, DZ,   1'b1, 4'b0000, 1'b1, 32'h100, 2'd0};
        vecs[6]  = '{4'b1111, DALL, 1'b1, 4'b0010, 1'b0, 32'h0,   2'd0};
        vecs[7]  = '{4'b1111, DALL, 1'b1, 4'b0100, 1'b1, 32'hD1,  2'd1};
        vecs[8]  = '{4'b1111, DALL, 1'b1, 4'b1000, 1'b1, 32'hD2,  2'd2};
        vecs[9]  = '{4'b1111, DALL, 1'b1, 4'b0001, 1'b1, 32'hD3,  2'd3};
        vecs[10] = '{4'b1111, DALL, 1'b1, 4'b0010, 1'b1, 32'hD0,  2'd0};
        vecs[11] = '{4'b0001, DALL, 1'b1, 4'b0001, 1'b1, 32'hD1,  2'd1};
        vecs[12] = '{4'b0000, DZ,   1'b1, 4'b0000, 1'b1, 32'hD0,  2'd0};
        vecs[13] = '{4'b1010, DBP,  1'b0, 4'b0010, 1'b0, 32'h0,   2'd0};
        vecs[14] = '{4'b1010, DBP,  1'b0, 4'b1000, 1'b1, 32'h11,  2'd1};
        vecs[15] = '{4'b1010, DBP,  1'b0, 4'b0000, 1'b1, 32'h11,  2'd1};
        vecs[16] = '{4'b1010, DBP,  1'b1, 4'b0000, 1'b1, 32'h11,  2'd1};
        vecs[17] = '{4'b1010, DBP,  1'b1, 4'b0010, 1'b1, 32'h33,  2'd3};
        vecs[18] = '{4'b0000, DZ,   1'b1, 4'b0000, 1'b1, 32'h11,  2'd1};
        vecs[19] = '{4'b0000, DZ,   1'b1, 4'b0000, 1'b0, 32'h0,   2'd0};

        // Reset with every stream requesting: nothing may be accepted.
        drive(1'b1, 4'b1111, DALL, 1'b1);
        check("reset_ready_in", 64'(ready_in), 64'h0);
        next_cycle();
        drive(1'b1, 4'b1111, DALL, 1'b1);
        check("reset_valid_out", 64'(valid_out), 64'h0);
        check("reset_ready_in_2", 64'(ready_in), 64'h0);
        next_cycle();

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, vecs[i].vin, vecs[i].din, vecs[i].ro);
            check($sformatf("row%0d_ready_in", i), 64'(ready_in), 64'(vecs[i].rin));
            check($sformatf("row%0d_valid_out", i), 64'(valid_out), 64'(vecs[i].vout));
            if (vecs[i].vout) begin
                check($sformatf("row%0d_data_out", i), 64'(data_out), 64'(vecs[i].dout));
                check($sformatf("row%0d_sel_out", i), 64'(sel_out), 64'(vecs[i].sel));
            end
            next_cycle();
        end

        // Reset mid-operation: buffer two beats (pointer ends at 2), then reset.
        drive(1'b0, 4'b0001, {96'h0, 32'h10}, 1'b0);
        check("mid_push1_ready", 64'(ready_in), 64'h1);
        next_cycle();
        drive(1'b0, 4'b0010, {64'h0, 32'h20, 32'h0}, 1'b0);
        check("mid_push2_ready", 64'(ready_in), 64'h2);
        next_cycle();
        drive(1'b1, 4'b1111, DALL, 1'b0);
        check("mid_reset_ready_in", 64'(ready_in), 64'h0);
        check("mid_full_valid_out", 64'(valid_out), 64'h1);
        next_cycle();
        drive(1'b0, 4'b1111, {96'h0, 32'h10}, 1'b1);
        check("post_reset_valid_out", 64'(valid_out), 64'h0);
        check("post_reset_grant_from_0", 64'(ready_in), 64'h1);
        next_cycle();

        // Simultaneous push and pop at count=1: 0x10 at head, 0x20 pushed behind it.
        drive(1'b0, 4'b0010, {64'h0, 32'h20, 32'h0}, 1'b1);
        check("pp_ready_in", 64'(ready_in), 64'h2);
        check("pp_valid_out", 64'(valid_out), 64'h1);
        check("pp_head_10", 64'(data_out), 64'h10);
        next_cycle();
        drive(1'b0, 4'b0000, DZ, 1'b0);
        check("pp_valid_after", 64'(valid_out), 64'h1);
        check("pp_head_20", 64'(data_out), 64'h20);
        check("pp_sel_1", 64'(sel_out), 64'h1);
        next_cycle();
        drive(1'b0, 4'b0000, DZ, 1'b1);
        check("pp_hold_20", 64'(data_out), 64'h20);
        check("pp_hold_valid", 64'(valid_out), 64'h1);
        next_cycle();
        drive(1'b0, 4'b0000, DZ, 1'b1);
        check("pp_drained", 64'(valid_out), 64'h0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
